fir_host_ctrl: RTL and testbench

FIR_HOST_CTRL -- requirements
Module: fir_host_ctrl

---
 rtl/fir_host_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fir_host_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_host_ctrl.sv
// Host-side sequencer for the FIR engine: streams samples into sample memory,
// kicks the FIR, waits for completion (with timeout) and streams results out.
module fir_host_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              START,
  input  logic              pracuje,
  input  logic              DONE,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, RD, HOLD, ERR} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d, len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_valid_q, m_valid_d, fresh_q, fresh_d, err_q, err_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic               last;

  // The FIR busy flag carries no control meaning here; completion is DONE alone.
  logic unused_pracuje;
  assign unused_pracuje = pracuje;

  assign last = (idx_q == len_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      fresh_q   <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      fresh_q   <= fresh_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    fresh_d   = 1'b0;
    m_data_d  = m_data_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    START     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_len != '0) begin
          len_d   = cmd_len;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mem_we = 1'b1;
          if (last) begin
            idx_d   = '0;
            state_d = KICK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      KICK: begin
        START   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // DONE wins over a timeout landing in the same cycle
        if (DONE) begin
          state_d = RD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD: begin
        mem_re    = 1'b1;
        m_valid_d = 1'b1;
        fresh_d   = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (fresh_q) m_data_d = mem_rdata;
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (last) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      START     = 1'b0;
    end
  end

  // Read data is forwarded on the HOLD entry cycle so results can flow every 2 cycles.
  assign m_data      = fresh_q ? mem_rdata : m_data_q;
  assign m_valid     = m_valid_q;
  assign mem_addr    = idx_q;
  assign mem_wdata   = s_data;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fir_host_ctrl.sv
// Scoreboard bench for fir_host_ctrl: memory/FIR models, result queue, timeout and reset cases.
module tb_fir_host_ctrl;
  localparam int DW = 16, AW = 10, TO = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_len = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic          START, pracuje = 1'b0, DONE = 1'b0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy, err_timeout;

  fir_host_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata),
    .START(START), .pracuje(pracuje), .DONE(DONE),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Result memory model: rdata = addr*10, one cycle after mem_re
  always @(posedge clk) if (mem_re) mem_rdata <= DW'(32'(mem_addr) * 10);

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_start = 0, n_re = 0, n_we = 0;
  int exp_q[$], wa_q[$], wd_q[$], hs_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      cyc++;
      if (START === 1'b1) n_start++;
      if (mem_re === 1'b1) n_re++;
      if (mem_we === 1'b1) begin
        n_we++;
        if (wa_q.size() > 0) begin
          chk("we_addr", 32'(mem_addr), wa_q.pop_front());
          chk("we_data", 32'(mem_wdata), wd_q.pop_front());
        end else chk("we_unexpected", 1, 0);
      end
      if (m_valid === 1'b1 && prev_v && !prev_r) chk("m_data_stable", 32'(m_data), 32'(prev_d));
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        hs_q.push_back(cyc);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", 32'(m_data), e);
        end else chk("result_unexpected", 1, 0);
      end
      prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
    end
  endtask

  task automatic issue(input int n, input bit push_res);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_len = AW'(n);
    step();
    cmd_valid = 1'b0;
    if (push_res) for (int i = 0; i < n; i++) exp_q.push_back(i * 10);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      chk("s_ready", s_ready, 1);
      s_valid = 1'b1; s_data = DW'(base + i);
      wa_q.push_back(i); wd_q.push_back(base + i);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int t = 0;
    while (START !== 1'b1 && t < 200) begin step(); t++; end
    ok = (START === 1'b1);
  endtask

  // FIR model: DONE pulse dly cycles after the START cycle
  task automatic fir_resp(input int dly);
    bit ok;
    wait_start(ok);
    chk("start_seen", ok, 1);
    if (ok) begin
      pracuje = 1'b1;
      repeat (dly) step();
      DONE = 1'b1; step(); DONE = 1'b0;
      pracuje = 1'b0;
    end
  endtask

  task automatic consume(input int n, input int stall);
    int got = 0, t = 0;
    while (got < n && t < 3000) begin
      if (m_valid === 1'b1) begin
        repeat (stall) begin step(); t++; end
        m_ready = 1'b1; step(); m_ready = 1'b0;
        got++;
      end else step();
      t++;
    end
    chk("consume_done", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_start, b_re, b_we, k;
    bit ok, bad;
    fork monitor(); join_none

    // Reset state
    repeat (3) step();
    chk("rst_start", START, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    step();

    // Nominal: 4 samples, DONE 12 cycles after START, free-flowing results
    b_start = n_start; b_re = n_re; b_we = n_we; hs_q.delete();
    issue(4, 1);
    fork load(4, 1); fir_resp(12); consume(4, 0); join
    chk("nom_busy_end", busy, 0);
    chk("nom_m_valid_end", m_valid, 0);
    chk("nom_start_cnt", n_start - b_start, 1);
    chk("nom_we_cnt", n_we - b_we, 4);
    chk("nom_re_cnt", n_re - b_re, 4);
    for (int i = 1; i < hs_q.size(); i++) chk("nom_throughput", hs_q[i] - hs_q[i-1], 2);

    // Backpressure: m_ready withheld 5 cycles per result
    b_re = n_re;
    issue(3, 1);
    fork load(3, 40); fir_resp(5); consume(3, 5); join
    chk("bp_re_cnt", n_re - b_re, 3);
    chk("bp_busy_end", busy, 0);

    // Timeout: no DONE; ERR comes 16 cycles after WAIT entry (17 after the START cycle)
    issue(2, 0);
    load(2, 100);
    wait_start(ok);
    chk("to_start_seen", ok, 1);
    k = 0;
    while (err_timeout !== 1'b1 && k < 100) begin step(); k++; end
    chk("to_cycles", k, 17);
    chk("to_busy_err", busy, 1);
    step();
    chk("to_busy_idle", busy, 0);
    chk("to_err_sticky", err_timeout, 1);
    repeat (4) step();
    chk("to_err_sticky2", err_timeout, 1);
    issue(1, 1);
    chk("to_err_cleared", err_timeout, 0);
    fork load(1, 7); fir_resp(3); consume(1, 0); join

    // Race: DONE on the last allowed WAIT cycle
    b_re = n_re;
    issue(2, 1);
    fork load(2, 30); fir_resp(16); consume(2, 0); join
    chk("race_err", err_timeout, 0);
    chk("race_re_cnt", n_re - b_re, 2);

    // Zero-length command is dropped
    b_start = n_start;
    chk("len0_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_len = '0;
    step();
    cmd_valid = 1'b0;
    bad = 1'b0;
    repeat (10) begin bad |= busy; step(); end
    chk("len0_busy", bad, 0);
    chk("len0_start", n_start - b_start, 0);

    // Reset during LOAD with s_valid high: no write, no START
    b_start = n_start;
    issue(3, 0);
    load(1, 50);
    s_valid = 1'b1; s_data = 16'd9; rst = 1'b1;
    #1;
    chk("rst_load_we", mem_we, 0);
    step();
    rst = 1'b0; s_valid = 1'b0;
    bad = 1'b0;
    repeat (20) begin bad |= busy; step(); end
    chk("rst_load_idle", bad, 0);
    chk("rst_load_start", n_start - b_start, 0);

    // Reset during WAIT, then a stale DONE pulse
    issue(2, 0);
    load(2, 20);
    wait_start(ok);
    chk("rw_start_seen", ok, 1);
    repeat (3) step();
    b_re = n_re;
    rst = 1'b1; step(); rst = 1'b0;
    DONE = 1'b1; step(); DONE = 1'b0;
    bad = 1'b0;
    repeat (10) begin bad |= busy | m_valid; step(); end
    chk("rw_idle", bad, 0);
    chk("rw_re_cnt", n_re - b_re, 0);

    chk("results_left", exp_q.size(), 0);
    chk("writes_left", wa_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
